imem_fetch_ctrl: RTL and testbench

Instruction-fetch controller for the single-ported, combinational `instruction_mem`. It owns the program counter and drives the memory address. It captures fetched words into a 2-entry prefetch buffer that feeds decode through a valid/ready handshake. It also arbitrates the same memory port with a debug read port, and applies branch/jump redirects by flushing the buffer.

---
 rtl/imem_fetch_ctrl.sv | 119 +++++++++++
 tb/tb_imem_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   Instruction-fetch front end for a single-ported, combinational instruction
//   memory. Owns the program counter, fills a 2-entry prefetch buffer that
//   feeds decode over a valid/ready handshake, shares the memory port with a
//   debug read port (debug wins), and flushes/restarts on redirects.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   imem_addr / imem_data   memory address out, instruction word back (same cycle)
//   fetch_en                allow new fetches; buffer keeps draining when low
//   instr_valid/instr/instr_pc/instr_ready
//                           buffer head toward decode
//   redirect_valid/redirect_pc
//                           one-cycle flush + restart request
//   dbg_req/dbg_addr        debug read request, held until dbg_ack
//   dbg_ack/dbg_data        one-cycle ack with registered read data
module imem_fetch_ctrl #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              fetch_en,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_data
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] word;
    } fetch_ent_t;

    fetch_ent_t [1:0]  fifo;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic [ADDR_W-1:0] fetch_pc;

    logic dbg_grant;
    logic pop;
    logic fetch_fire;

    // The ack cycle masks the grant, so even a permanently asserted debug
    // request leaves every other cycle free for fetch.
    assign dbg_grant   = dbg_req & ~dbg_ack;
    assign imem_addr   = dbg_grant ? dbg_addr : fetch_pc;

    assign instr_valid = (count != 2'd0);
    assign instr       = fifo[rd_ptr].word;
    assign instr_pc    = fifo[rd_ptr].pc;

    assign pop         = instr_valid & instr_ready;
    // A full buffer may still accept a fetch when its head leaves this cycle.
    assign fetch_fire  = fetch_en & ~dbg_grant & ~redirect_valid &
                         ((count != 2'd2) | pop);

    // Pointers, occupancy and PC. Redirect discards everything buffered; a
    // pop in that cycle has already been consumed by decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            fetch_pc <= redirect_pc;
        end else begin
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (fetch_fire) begin
                wr_ptr   <= ~wr_ptr;
                fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
            end
            case ({fetch_fire, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Buffer storage; cleared on reset so the head reads zero before the
    // first fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo <= '0;
        end else if (fetch_fire) begin
            fifo[wr_ptr] <= '{pc: fetch_pc, word: imem_data};
        end
    end

    // Debug read: data captured in the grant cycle, ack pulses the next.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbg_ack  <= 1'b0;
            dbg_data <= '0;
        end else begin
            dbg_ack <= dbg_grant;
            if (dbg_grant)
                dbg_data <= imem_data;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: a queue-based model of the fetch buffer is
// compared against the DUT every falling edge, and directed phases pin the
// model with hand-computed literal expectations.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        reset_n;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        fetch_en;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        dbg_req;
    logic [15:0] dbg_addr;
    logic        dbg_ack;
    logic [15:0] dbg_data;

    logic [15:0] mem_xor;
    int          n_chk;
    int          n_pass;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .fetch_en       (fetch_en),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dbg_req        (dbg_req),
        .dbg_addr       (dbg_addr),
        .dbg_ack        (dbg_ack),
        .dbg_data       (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: word = address ^ mem_xor (mem_xor = 0 gives word = address).
    always_comb imem_data = imem_addr ^ mem_xor;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ mem_xor;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] pc;
        logic [15:0] word;
    } ent_t;

    ent_t        m_q[$];
    logic [15:0] m_pc;
    logic        m_ack;
    logic [15:0] m_ddata;

    task automatic model_step();
        logic grant, pop, fire;
        logic [15:0] addr;
        ent_t e;
        if (!reset_n) begin
            m_q.delete();
            m_pc    = 16'h0000;
            m_ack   = 1'b0;
            m_ddata = 16'h0000;
        end else begin
            grant = dbg_req && !m_ack;
            pop   = (m_q.size() != 0) && instr_ready;
            fire  = fetch_en && !grant && !redirect_valid && ((m_q.size() < 2) || pop);
            addr  = grant ? dbg_addr : m_pc;
            if (grant) m_ddata = mem_word(addr);
            m_ack = grant;
            if (pop) void'(m_q.pop_front());
            if (redirect_valid) begin
                m_q.delete();
                m_pc = redirect_pc;
            end else if (fire) begin
                e.pc   = m_pc;
                e.word = mem_word(m_pc);
                m_q.push_back(e);
                m_pc = m_pc + 16'd2;
            end
        end
    endtask

    always @(posedge clk or negedge reset_n) model_step();

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("imem_addr", {16'h0, imem_addr},
                {16'h0, (dbg_req && !m_ack) ? dbg_addr : m_pc});
            chk("instr_valid", {31'h0, instr_valid}, {31'h0, m_q.size() != 0});
            if (m_q.size() != 0) begin
                chk("instr_pc", {16'h0, instr_pc}, {16'h0, m_q[0].pc});
                chk("instr", {16'h0, instr}, {16'h0, m_q[0].word});
            end
            chk("dbg_ack", {31'h0, dbg_ack}, {31'h0, m_ack});
            chk("dbg_data", {16'h0, dbg_data}, {16'h0, m_ddata});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string nm, input logic [15:0] pc, input logic [15:0] word);
        chk({nm, "_valid"}, {31'h0, instr_valid}, 32'h1);
        chk({nm, "_pc"}, {16'h0, instr_pc}, {16'h0, pc});
        chk({nm, "_instr"}, {16'h0, instr}, {16'h0, word});
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset_n = 1'b0;
        fetch_en = 1'b1;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0;
        dbg_req = 1'b0;
        dbg_addr = 16'h0;
        mem_xor = 16'h0;

        // Reset values
        #12;
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_ack", {31'h0, dbg_ack}, 32'h0);
        chk("rst_dbg_data", {16'h0, dbg_data}, 32'h0);
        chk("rst_instr", {16'h0, instr}, 32'h0);
        chk("rst_instr_pc", {16'h0, instr_pc}, 32'h0);
        chk("rst_imem_addr", {16'h0, imem_addr}, 32'h0);

        // Streaming from reset: 0000, 0002, 0004 on consecutive cycles
        tick();
        reset_n = 1'b1;
        tick(); chk_head("s0", 16'h0000, 16'h0000);
        tick(); chk_head("s1", 16'h0002, 16'h0002);
        tick(); chk_head("s2", 16'h0004, 16'h0004);

        // Stall from reset: buffer saturates, fetch_pc holds at 0004
        reset_n = 1'b0;
        #1;
        instr_ready = 1'b0;
        reset_n = 1'b1;
        repeat (5) tick();
        chk_head("stall", 16'h0000, 16'h0000);
        chk("stall_addr", {16'h0, imem_addr}, 32'h0004);
        instr_ready = 1'b1;
        tick(); chk_head("rel1", 16'h0002, 16'h0002);
        tick(); chk_head("rel2", 16'h0004, 16'h0004);

        // Redirect while full
        instr_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc = 16'h001A;
        tick();
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        chk("redir_flush", {31'h0, instr_valid}, 32'h0);
        tick(); chk_head("redir0", 16'h001A, 16'h001A);
        tick(); chk_head("redir1", 16'h001C, 16'h001C);

        // Continuous debug traffic during streaming
        mem_xor = 16'h5A5A;
        dbg_addr = 16'h002E;
        dbg_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("dbg_ack_alt", {31'h0, dbg_ack}, {31'h0, (i % 2) == 0});
            if (dbg_ack) chk("dbg_data_lit", {16'h0, dbg_data}, {16'h0, 16'h002E ^ 16'h5A5A});
        end
        dbg_req = 1'b0;
        tick();
        tick();

        // Wrap-around redirect
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_flush", {31'h0, instr_valid}, 32'h0);
        tick(); chk_head("wrap0", 16'hFFFE, 16'hFFFE ^ 16'h5A5A);
        tick(); chk_head("wrap1", 16'h0000, 16'h0000 ^ 16'h5A5A);

        // Async reset in the middle of a debug grant
        dbg_addr = 16'h0040;
        dbg_req = 1'b1;
        #3;
        reset_n = 1'b0;
        dbg_req = 1'b0;
        #1;
        chk("arst_valid", {31'h0, instr_valid}, 32'h0);
        chk("arst_ack", {31'h0, dbg_ack}, 32'h0);
        chk("arst_dbg_data", {16'h0, dbg_data}, 32'h0);
        chk("arst_instr", {16'h0, instr}, 32'h0);
        chk("arst_instr_pc", {16'h0, instr_pc}, 32'h0);
        chk("arst_imem_addr", {16'h0, imem_addr}, 32'h0);
        tick();
        chk("arst_no_ack", {31'h0, dbg_ack}, 32'h0);
        reset_n = 1'b1;
        tick();
        chk("post_no_ack", {31'h0, dbg_ack}, 32'h0);
        chk_head("post0", 16'h0000, 16'h0000 ^ 16'h5A5A);
        tick(); chk_head("post1", 16'h0002, 16'h0002 ^ 16'h5A5A);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
